// File: rtl/matmul_sequencer_if.sv
// Handshake and memory/datapath control bundle for the matrix-multiply sequencer.
// master = sequencer side, slave = controller/datapath/memory side.
interface matmul_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] dim_m;
    logic [ADDR_WIDTH-1:0] dim_k;
    logic [ADDR_WIDTH-1:0] dim_n;
    logic                  busy;
    logic                  done;
    logic                  cfg_error;
    logic                  en_ReadMat_A;
    logic [ADDR_WIDTH-1:0] rowAddr_A;
    logic [ADDR_WIDTH-1:0] colAddr_A;
    logic                  en_ReadMat_B;
    logic [ADDR_WIDTH-1:0] rowAddr_B;
    logic [ADDR_WIDTH-1:0] colAddr_B;
    logic                  en_Mux;
    logic                  en_PPReg;
    logic                  en_FDReg;
    logic                  en_WriteMat_C;
    logic [ADDR_WIDTH-1:0] rowAddr_C;
    logic [ADDR_WIDTH-1:0] colAddr_C;

    modport master (
        input  start, dim_m, dim_k, dim_n,
        output busy, done, cfg_error,
        output en_ReadMat_A, rowAddr_A, colAddr_A,
        output en_ReadMat_B, rowAddr_B, colAddr_B,
        output en_Mux, en_PPReg, en_FDReg,
        output en_WriteMat_C, rowAddr_C, colAddr_C
    );

    modport slave (
        output start, dim_m, dim_k, dim_n,
        input  busy, done, cfg_error,
        input  en_ReadMat_A, rowAddr_A, colAddr_A,
        input  en_ReadMat_B, rowAddr_B, colAddr_B,
        input  en_Mux, en_PPReg, en_FDReg,
        input  en_WriteMat_C, rowAddr_C, colAddr_C
    );
endinterface

// File: rtl/matmul_sequencer.sv
// Run-time configurable sequencer for the 8-bit matrix-multiply datapath.
// Walks C[i][j] in row-major order; each element spends K cycles in READ,
// then one cycle each in ACC, LATCH and WRITE. Outputs are decoded from state.
module matmul_sequencer #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned MAX_DIM    = 10
) (
    input logic               clk,
    input logic               reset_n,
    matmul_sequencer_if.master bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] ACC   = 3'd2;
    localparam logic [2:0] LATCH = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] DIM_MAX = ADDR_WIDTH'(MAX_DIM);
    localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] i_q, i_d;
    logic [ADDR_WIDTH-1:0] j_q, j_d;
    logic [ADDR_WIDTH-1:0] k_q, k_d;
    logic [ADDR_WIDTH-1:0] dm_q, dm_d;
    logic [ADDR_WIDTH-1:0] dk_q, dk_d;
    logic [ADDR_WIDTH-1:0] dn_q, dn_d;
    logic                  cfg_err_q, cfg_err_d;

    logic dims_ok;
    logic last_k, last_col, last_row;

    assign dims_ok = (bus.dim_m != '0) && (bus.dim_m <= DIM_MAX) &&
                     (bus.dim_k != '0) && (bus.dim_k <= DIM_MAX) &&
                     (bus.dim_n != '0) && (bus.dim_n <= DIM_MAX);
    assign last_k   = (k_q == dk_q - ONE);
    assign last_col = (j_q == dn_q - ONE);
    assign last_row = (i_q == dm_q - ONE);

    // Next-state, loop counters and dimension latch.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        dm_d      = dm_q;
        dk_d      = dk_q;
        dn_d      = dn_q;
        cfg_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (dims_ok) begin
                        dm_d    = bus.dim_m;
                        dk_d    = bus.dim_k;
                        dn_d    = bus.dim_n;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                        state_d = READ;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (last_k) begin
                    state_d = ACC;
                end else begin
                    k_d = k_q + ONE;
                end
            end
            ACC:   state_d = LATCH;
            LATCH: state_d = WRITE;
            WRITE: begin
                k_d = '0;
                if (last_col) begin
                    j_d = '0;
                    i_d = i_q + ONE;
                end else begin
                    j_d = j_q + ONE;
                end
                state_d = (last_col && last_row) ? DONE : READ;
            end
            DONE: begin
                // Counters are left clean for the next job; a start here is ignored.
                i_d     = '0;
                j_d     = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            dm_q      <= '0;
            dk_q      <= '0;
            dn_q      <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            dm_q      <= dm_d;
            dk_q      <= dk_d;
            dn_q      <= dn_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    logic                  busy, done;
    logic                  rd_en, pp_en, mux_en, fd_en, wr_en;
    logic [ADDR_WIDTH-1:0] row_a, col_a, row_b, col_b, row_c, col_c;

    // Output decode; addresses stay zero whenever their enable is low.
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        rd_en  = 1'b0;
        pp_en  = 1'b0;
        mux_en = 1'b0;
        fd_en  = 1'b0;
        wr_en  = 1'b0;
        row_a  = '0;
        col_a  = '0;
        row_b  = '0;
        col_b  = '0;
        row_c  = '0;
        col_c  = '0;
        case (state_q)
            READ: begin
                busy   = 1'b1;
                rd_en  = 1'b1;
                row_a  = i_q;
                col_a  = k_q;
                row_b  = k_q;
                col_b  = j_q;
                // Data read at k-1 arrives now; the first product loads, later ones add.
                pp_en  = (k_q != '0);
                mux_en = (k_q > ONE);
            end
            ACC: begin
                busy   = 1'b1;
                pp_en  = 1'b1;
                mux_en = (dk_q > ONE);
            end
            LATCH: begin
                busy  = 1'b1;
                fd_en = 1'b1;
            end
            WRITE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                row_c = i_q;
                col_c = j_q;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.cfg_error     = cfg_err_q;
    assign bus.en_ReadMat_A  = rd_en;
    assign bus.rowAddr_A     = row_a;
    assign bus.colAddr_A     = col_a;
    assign bus.en_ReadMat_B  = rd_en;
    assign bus.rowAddr_B     = row_b;
    assign bus.colAddr_B     = col_b;
    assign bus.en_Mux        = mux_en;
    assign bus.en_PPReg      = pp_en;
    assign bus.en_FDReg      = fd_en;
    assign bus.en_WriteMat_C = wr_en;
    assign bus.rowAddr_C     = row_c;
    assign bus.colAddr_C     = col_c;
endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer with a behavioural datapath and memories.
module tb_matmul_sequencer;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    matmul_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

    matmul_sequencer #(.ADDR_WIDTH(AW), .MAX_DIM(10)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural memories and datapath, 1-cycle read latency.
    logic [7:0]  mem_a [10][10];
    logic [7:0]  mem_b [10][10];
    logic [7:0]  a_rd = '0, b_rd = '0;
    logic [15:0] pp = '0, fd = '0;
    logic [15:0] prod;
    assign prod = 16'(a_rd) * 16'(b_rd);

    always @(posedge clk) begin
        if (bus.en_ReadMat_A) a_rd <= mem_a[bus.rowAddr_A][bus.colAddr_A];
        if (bus.en_ReadMat_B) b_rd <= mem_b[bus.rowAddr_B][bus.colAddr_B];
        if (bus.en_PPReg) pp <= bus.en_Mux ? pp + prod : prod;
        if (bus.en_FDReg) fd <= pp;
    end

    typedef struct packed {
        logic [3:0]  r;
        logic [3:0]  c;
        logic [15:0] v;
    } wr_t;
    wr_t exp_q[$];

    int busy_tot = 0, done_tot = 0, cfg_tot = 0, rd_tot = 0, wr_tot = 0, mux_tot = 0;

    // Monitor: counts activity and checks each C write against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.busy)          busy_tot++;
            if (bus.done)          done_tot++;
            if (bus.cfg_error)     cfg_tot++;
            if (bus.en_ReadMat_A || bus.en_ReadMat_B) rd_tot++;
            if (bus.en_Mux)        mux_tot++;
            if (bus.en_WriteMat_C) begin
                wr_tot++;
                if (exp_q.size() == 0) begin
                    chk("c_write_unexpected", 64'(exp_q.size()), 64'd1);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("c_write", {bus.rowAddr_C, bus.colAddr_C, fd}, e);
                end
            end
            chk("addr_zero_when_disabled",
                (!bus.en_ReadMat_A  && (bus.rowAddr_A != 0 || bus.colAddr_A != 0)) ||
                (!bus.en_ReadMat_B  && (bus.rowAddr_B != 0 || bus.colAddr_B != 0)) ||
                (!bus.en_WriteMat_C && (bus.rowAddr_C != 0 || bus.colAddr_C != 0)), 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [32:0] all_outs();
        return {bus.busy, bus.done, bus.cfg_error,
                bus.en_ReadMat_A, bus.rowAddr_A, bus.colAddr_A,
                bus.en_ReadMat_B, bus.rowAddr_B, bus.colAddr_B,
                bus.en_Mux, bus.en_PPReg, bus.en_FDReg,
                bus.en_WriteMat_C, bus.rowAddr_C, bus.colAddr_C};
    endfunction

    // {rdA,rowA,colA,rdB,rowB,colB,pp,mux,fd,wr,rowC,colC}
    function automatic logic [29:0] trace_now();
        return {bus.en_ReadMat_A, bus.rowAddr_A, bus.colAddr_A,
                bus.en_ReadMat_B, bus.rowAddr_B, bus.colAddr_B,
                bus.en_PPReg, bus.en_Mux, bus.en_FDReg,
                bus.en_WriteMat_C, bus.rowAddr_C, bus.colAddr_C};
    endfunction

    function automatic logic [29:0] trace_exp(input int c);
        case (c)
            1: return {1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
            2: return {1'b1, 4'd0, 4'd1, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
            3: return {1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0};
            4: return {1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
            default:
               return {1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0};
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives start for cycle 0; returns at the start of cycle 1.
    task automatic issue(input int m, input int k, input int n);
        bus.dim_m = AW'(m);
        bus.dim_k = AW'(k);
        bus.dim_n = AW'(n);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 0;
        for (int t = 0; t < budget && !seen; t++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        chk(name, 64'(seen), 64'd1);
        cyc();
        cyc();
    endtask

    task automatic push(input int r, input int c, input int v);
        wr_t e;
        e.r = 4'(r);
        e.c = 4'(c);
        e.v = 16'(v);
        exp_q.push_back(e);
    endtask

    task automatic load_2x2();
        mem_a[0][0] = 8'd1; mem_a[0][1] = 8'd2; mem_a[1][0] = 8'd3; mem_a[1][1] = 8'd4;
        mem_b[0][0] = 8'd5; mem_b[0][1] = 8'd6; mem_b[1][0] = 8'd7; mem_b[1][1] = 8'd8;
    endtask

    task automatic push_2x2();
        push(0, 0, 19); push(0, 1, 22); push(1, 0, 43); push(1, 1, 50);
    endtask

    initial begin
        int b0, d0, c0, r0, w0, m0;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.dim_m = '0;
        bus.dim_k = '0;
        bus.dim_n = '0;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++) begin
                mem_a[r][c] = '0;
                mem_b[r][c] = '0;
            end
        cyc(); cyc(); cyc();
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_outputs_zero", 64'(all_outs()), 64'd0);
        cyc();

        // 2x2x2 with cycle-exact trace of the first element.
        load_2x2();
        push_2x2();
        b0 = busy_tot; d0 = done_tot;
        issue(2, 2, 2);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("trace_2x2_cycle%0d", c), 64'(trace_now()), 64'(trace_exp(c)));
        end
        wait_done("done_2x2", 40);
        chk("busy_cycles_2x2", 64'(busy_tot - b0), 64'd20);
        chk("done_pulses_2x2", 64'(done_tot - d0), 64'd1);

        // 10x10x10 identity.
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++) begin
                mem_a[r][c] = (r == c) ? 8'd1 : 8'd0;
                mem_b[r][c] = (r == c) ? 8'd1 : 8'd0;
                push(r, c, (r == c) ? 1 : 0);
            end
        b0 = busy_tot; d0 = done_tot; w0 = wr_tot;
        issue(10, 10, 10);
        wait_done("done_identity", 1400);
        chk("busy_cycles_identity", 64'(busy_tot - b0), 64'd1300);
        chk("writes_identity", 64'(wr_tot - w0), 64'd100);
        chk("done_pulses_identity", 64'(done_tot - d0), 64'd1);

        // K=1, M=3, N=2: no accumulation ever.
        mem_a[0][0] = 8'd2; mem_a[1][0] = 8'd3; mem_a[2][0] = 8'd4;
        mem_b[0][0] = 8'd5; mem_b[0][1] = 8'd6;
        push(0, 0, 10); push(0, 1, 12); push(1, 0, 15);
        push(1, 1, 18); push(2, 0, 20); push(2, 1, 24);
        b0 = busy_tot; m0 = mux_tot; w0 = wr_tot;
        issue(3, 1, 2);
        wait_done("done_k1", 40);
        chk("busy_cycles_k1", 64'(busy_tot - b0), 64'd24);
        chk("mux_never_k1", 64'(mux_tot - m0), 64'd0);
        chk("writes_k1", 64'(wr_tot - w0), 64'd6);

        // Rejected configurations.
        for (int t = 0; t < 2; t++) begin
            b0 = busy_tot; c0 = cfg_tot; r0 = rd_tot; w0 = wr_tot;
            if (t == 0) issue(2, 0, 2);
            else        issue(2, 2, 11);
            @(negedge clk);
            chk($sformatf("cfg_error_pulse_%0d", t), 64'(bus.cfg_error), 64'd1);
            cyc(); cyc(); cyc(); cyc();
            chk($sformatf("cfg_error_count_%0d", t), 64'(cfg_tot - c0), 64'd1);
            chk($sformatf("cfg_busy_%0d", t), 64'(busy_tot - b0), 64'd0);
            chk($sformatf("cfg_no_mem_%0d", t), 64'((rd_tot - r0) + (wr_tot - w0)), 64'd0);
        end

        // Start re-asserted in cycle 7 of a 2x2x2 job is ignored.
        load_2x2();
        push_2x2();
        b0 = busy_tot; d0 = done_tot;
        issue(2, 2, 2);
        for (int c = 1; c < 7; c++) cyc();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        wait_done("done_restart", 40);
        cyc(); cyc(); cyc();
        chk("busy_cycles_restart", 64'(busy_tot - b0), 64'd20);
        chk("done_pulses_restart", 64'(done_tot - d0), 64'd1);

        // Reset in cycle 10 of a 10x10x10 job; no C write can have occurred yet.
        d0 = done_tot; w0 = wr_tot;
        issue(10, 10, 10);
        for (int c = 1; c < 10; c++) cyc();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        @(negedge clk);
        chk("midjob_reset_outputs_zero", 64'(all_outs()), 64'd0);
        for (int c = 0; c < 20; c++) cyc();
        chk("midjob_reset_no_done", 64'(done_tot - d0), 64'd0);
        chk("midjob_reset_no_write", 64'(wr_tot - w0), 64'd0);

        load_2x2();
        push_2x2();
        b0 = busy_tot; d0 = done_tot;
        issue(2, 2, 2);
        wait_done("done_after_reset", 40);
        chk("busy_cycles_after_reset", 64'(busy_tot - b0), 64'd20);
        chk("done_pulses_after_reset", 64'(done_tot - d0), 64'd1);

        cyc(); cyc();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
